// File: rtl/result_uart_tx_if.sv
// Result-to-UART handshake bundle: one-cycle result strobe in, serial line and status out.
interface result_uart_tx_if;
  logic        i_valid;
  logic [17:0] i_result;
  logic [25:0] i_time;
  logic        o_txd;
  logic        o_busy;
  logic        o_drop;

  modport master (output i_valid, i_result, i_time, input o_txd, o_busy, o_drop);
  modport slave  (input i_valid, i_result, i_time, output o_txd, o_busy, o_drop);
endinterface

// File: rtl/result_uart_tx.sv
// Sends "RRRRR TTTTTTT\r\n" (hex score, hex time) as 8N1 UART, with a one-deep pending frame slot.
module result_uart_tx #(
  parameter int BAUD_DIV = 434
) (
  input logic             clk,
  input logic             rst,
  result_uart_tx_if.slave u
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state, state_nxt;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [3:0]  byte_idx;
  logic        pend_vld;
  logic        drop_p1;
  logic [17:0] cur_result, pend_result;
  logic [25:0] cur_time, pend_time;
  logic [19:0] res_w;
  logic [27:0] tim_w;
  logic [7:0]  cur_byte;
  logic        txd;
  logic        baud_done, last_stop;
  logic        take_new, take_pend, fill_pend;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
  endfunction

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign last_stop = (state == STOP) && baud_done && (byte_idx == 4'd14);

  // A new request either starts a frame now, parks in the pending slot, or is dropped.
  // At frame end the pending frame is promoted, which frees the slot for a simultaneous request.
  assign take_pend = pend_vld && ((state == IDLE) || last_stop);
  assign take_new  = u.i_valid && !pend_vld && ((state == IDLE) || last_stop);
  assign fill_pend = u.i_valid && !take_new && (!pend_vld || take_pend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (u.i_valid || pend_vld) state_nxt = START;
      START: if (baud_done) state_nxt = DATA;
      DATA:  if (baud_done && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP: begin
        if (baud_done) begin
          if (byte_idx != 4'd14)            state_nxt = START;
          else if (u.i_valid || pend_vld)   state_nxt = START;
          else                              state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      pend_vld <= 1'b0;
      drop_p1  <= 1'b0;
    end else begin
      if ((state == IDLE) || baud_done) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + 16'd1;
      if ((state == DATA) && baud_done) bit_idx <= bit_idx + 3'd1;
      if ((state == STOP) && baud_done)
        byte_idx <= (byte_idx == 4'd14) ? 4'd0 : byte_idx + 4'd1;
      if (fill_pend)      pend_vld <= 1'b1;
      else if (take_pend) pend_vld <= 1'b0;
      drop_p1 <= u.i_valid && !take_new && !fill_pend;
    end
  end

  // Payload registers carry no reset; they are only read while a frame is active.
  always_ff @(posedge clk) begin
    if (take_new) begin
      cur_result <= u.i_result;
      cur_time   <= u.i_time;
    end else if (take_pend) begin
      cur_result <= pend_result;
      cur_time   <= pend_time;
    end
    if (fill_pend) begin
      pend_result <= u.i_result;
      pend_time   <= u.i_time;
    end
  end

  assign res_w = {2'b00, cur_result};
  assign tim_w = {2'b00, cur_time};

  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx)
      4'd0:    cur_byte = hex_ascii(res_w[19:16]);
      4'd1:    cur_byte = hex_ascii(res_w[15:12]);
      4'd2:    cur_byte = hex_ascii(res_w[11:8]);
      4'd3:    cur_byte = hex_ascii(res_w[7:4]);
      4'd4:    cur_byte = hex_ascii(res_w[3:0]);
      4'd5:    cur_byte = 8'h20;
      4'd6:    cur_byte = hex_ascii(tim_w[27:24]);
      4'd7:    cur_byte = hex_ascii(tim_w[23:20]);
      4'd8:    cur_byte = hex_ascii(tim_w[19:16]);
      4'd9:    cur_byte = hex_ascii(tim_w[15:12]);
      4'd10:   cur_byte = hex_ascii(tim_w[11:8]);
      4'd11:   cur_byte = hex_ascii(tim_w[7:4]);
      4'd12:   cur_byte = hex_ascii(tim_w[3:0]);
      4'd13:   cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = cur_byte[bit_idx];
      default: txd = 1'b1;
    endcase
  end

  assign u.o_txd  = txd;
  assign u.o_busy = (state != IDLE) || pend_vld;
  assign u.o_drop = drop_p1;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: vector table, corner-case sequences and a cycle-level frame schedule model.
module tb_result_uart_tx;
  localparam int BAUD  = 4;
  localparam int FRAME = 150 * BAUD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  result_uart_tx_if bus();

  result_uart_tx #(.BAUD_DIV(BAUD)) dut (.clk(clk), .rst(rst), .u(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got \"%s\", want \"%s\"", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
  endfunction

  function automatic logic [7:0] fbyte(input logic [17:0] r, input logic [25:0] t, input int i);
    logic [19:0] rr;
    logic [27:0] tt;
    rr = {2'b00, r};
    tt = {2'b00, t};
    if (i < 5)   return hexc(rr[4*(4-i) +: 4]);
    if (i == 5)  return 8'h20;
    if (i < 13)  return hexc(tt[4*(12-i) +: 4]);
    if (i == 13) return 8'h0D;
    return 8'h0A;
  endfunction

  function automatic string frame_text(input logic [17:0] r, input logic [25:0] t);
    string s;
    s = "";
    for (int i = 0; i < 13; i++) s = {s, $sformatf("%c", fbyte(r, t, i))};
    return s;
  endfunction

  // Reference: list of scheduled frames with their first line cycle; the line at any cycle
  // follows from the offset into the owning frame. At most two frames may be outstanding.
  typedef struct {
    int          s;
    logic [17:0] r;
    logic [25:0] t;
  } frm_t;

  frm_t q[$];
  int   e = 0;
  int   busy_until = -1;
  logic exp_drop = 1'b0;

  always @(posedge clk) begin
    frm_t f;
    int   off, bp, bi, bb;
    logic exp_txd;
    logic [7:0] byt;
    e++;
    exp_drop = 1'b0;
    if (rst) begin
      q.delete();
      busy_until = -1;
    end else begin
      while (q.size() > 0 && (q[0].s + FRAME - 1 < e)) void'(q.pop_front());
      if (bus.i_valid) begin
        if (q.size() < 2) begin
          f.s = (q.size() == 0) ? e : q[q.size()-1].s + FRAME;
          f.r = bus.i_result;
          f.t = bus.i_time;
          q.push_back(f);
          busy_until = f.s + FRAME - 1;
        end else begin
          exp_drop = 1'b1;
        end
      end
    end
    #2;
    exp_txd = 1'b1;
    foreach (q[i]) begin
      if (q[i].s <= e && e <= q[i].s + FRAME - 1) begin
        off = e - q[i].s;
        bp  = off / BAUD;
        bi  = bp / 10;
        bb  = bp % 10;
        byt = fbyte(q[i].r, q[i].t, bi);
        if (bb == 0)      exp_txd = 1'b0;
        else if (bb == 9) exp_txd = 1'b1;
        else              exp_txd = byt[bb-1];
      end
    end
    chk($sformatf("txd@%0d", e),  64'(bus.o_txd),  64'(exp_txd));
    chk($sformatf("busy@%0d", e), 64'(bus.o_busy), 64'(e <= busy_until));
    chk($sformatf("drop@%0d", e), 64'(bus.o_drop), 64'(exp_drop));
  end

  logic [7:0] rx [15];

  function automatic string rx_text();
    string s;
    s = "";
    for (int i = 0; i < 13; i++) s = {s, $sformatf("%c", rx[i])};
    return s;
  endfunction

  task automatic pulse(input logic [17:0] r, input logic [25:0] t);
    @(negedge clk);
    bus.i_result = r;
    bus.i_time   = t;
    bus.i_valid  = 1'b1;
    @(negedge clk);
    bus.i_valid  = 1'b0;
  endtask

  task automatic recv_frame(input string name);
    int n;
    for (int k = 0; k < 15; k++) begin
      n = 0;
      while (bus.o_txd !== 1'b0 && n < 3 * FRAME) begin
        @(negedge clk);
        n++;
      end
      if (n >= 3 * FRAME) begin
        chk($sformatf("%s start%0d timeout", name, k), 64'(0), 64'(1));
        for (int j = 0; j < 15; j++) rx[j] = 8'h00;
        return;
      end
      repeat (BAUD / 2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        repeat (BAUD) @(negedge clk);
        rx[k][j] = bus.o_txd;
      end
      repeat (BAUD) @(negedge clk);
      chk($sformatf("%s stop%0d", name, k), 64'(bus.o_txd), 64'(1));
    end
  endtask

  task automatic check_rx(input string name, input string txt);
    chk_str({name, " text"}, rx_text(), txt);
    chk({name, " cr"}, 64'(rx[13]), 64'(8'h0D));
    chk({name, " lf"}, 64'(rx[14]), 64'(8'h0A));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.o_busy && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("idle reached", 64'(bus.o_busy), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [17:0] r;
    logic [25:0] t;
    string       txt;
    int          busy_cycles;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int nb, lows, falls;
    logic prev;
    logic [17:0] r;
    logic [25:0] t;
    bus.i_valid  = 1'b0;
    bus.i_result = '0;
    bus.i_time   = '0;
    tbl[0] = '{18'h2ABCD, 26'h0000010, "2ABCD 0000010", 600};
    tbl[1] = '{18'h00000, 26'h0000000, "00000 0000000", 600};
    tbl[2] = '{18'h3FFFF, 26'h3FFFFFF, "3FFFF 3FFFFFF", 600};
    tbl[3] = '{18'h1A5F0, 26'h2B4C6D8, "1A5F0 2B4C6D8", 600};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset txd",  64'(bus.o_txd),  64'(1));
    chk("reset busy", 64'(bus.o_busy), 64'(0));
    chk("reset drop", 64'(bus.o_drop), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      pulse(tbl[i].r, tbl[i].t);
      chk($sformatf("tbl%0d first txd", i), 64'(bus.o_txd),  64'(0));
      chk($sformatf("tbl%0d first busy", i), 64'(bus.o_busy), 64'(1));
      nb = 0;
      fork
        recv_frame($sformatf("tbl%0d", i));
        begin
          while (bus.o_busy && nb < 4 * FRAME) begin
            @(negedge clk);
            nb++;
          end
        end
      join
      check_rx($sformatf("tbl%0d", i), tbl[i].txt);
      chk($sformatf("tbl%0d busy len", i), 64'(nb), 64'(tbl[i].busy_cycles));
      wait_idle();
    end

    // Second request parks in the pending slot and follows with no gap.
    pulse(18'h00001, 26'h0000001);
    nb = 0;
    fork
      begin
        recv_frame("buf1");
        check_rx("buf1", "00001 0000001");
        recv_frame("buf2");
        check_rx("buf2", "3FFFF 3FFFFFF");
      end
      begin
        repeat (8) @(negedge clk);
        pulse(18'h3FFFF, 26'h3FFFFFF);
      end
      begin
        while (bus.o_busy && nb < 4 * FRAME) begin
          @(negedge clk);
          nb++;
        end
      end
    join
    chk("buf busy len", 64'(nb), 64'(2 * FRAME));
    wait_idle();

    // Third request inside the first byte finds the slot full.
    pulse(18'h0AAAA, 26'h0000AAA);
    fork
      begin
        recv_frame("drop1");
        check_rx("drop1", "0AAAA 0000AAA");
        recv_frame("drop2");
        check_rx("drop2", "0BBBB 0000BBB");
      end
      begin
        pulse(18'h0BBBB, 26'h0000BBB);
        chk("drop quiet", 64'(bus.o_drop), 64'(0));
        pulse(18'h0CCCC, 26'h0000CCC);
        chk("drop pulse", 64'(bus.o_drop), 64'(1));
        @(negedge clk);
        chk("drop one cycle", 64'(bus.o_drop), 64'(0));
      end
    join
    falls = 0;
    prev  = bus.o_txd;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (prev && !bus.o_txd) falls++;
      prev = bus.o_txd;
    end
    chk("drop no third frame", 64'(falls), 64'(0));
    wait_idle();

    // Request on the final stop cycle with the slot empty.
    pulse(18'h12345, 26'h0ABCDEF);
    lows = 0;
    fork
      begin
        recv_frame("colA");
        check_rx("colA", "12345 0ABCDEF");
        recv_frame("colB");
        check_rx("colB", "2FEDC 3012345");
      end
      begin
        repeat (598) @(negedge clk);
        pulse(18'h2FEDC, 26'h3012345);
        chk("col no drop", 64'(bus.o_drop), 64'(0));
      end
      begin
        for (int k = 0; k < 2 * FRAME - 1; k++) begin
          if (!bus.o_busy) lows++;
          @(negedge clk);
        end
      end
    join
    chk("col busy held", 64'(lows), 64'(0));
    wait_idle();

    // Request on the final stop cycle with the slot full.
    pulse(18'h11111, 26'h1111111);
    fork
      begin
        recv_frame("colF1");
        check_rx("colF1", "11111 1111111");
        recv_frame("colF2");
        check_rx("colF2", "22222 2222222");
        recv_frame("colF3");
        check_rx("colF3", "33333 3333333");
      end
      begin
        pulse(18'h22222, 26'h2222222);
        repeat (596) @(negedge clk);
        pulse(18'h33333, 26'h3333333);
        chk("colF no drop", 64'(bus.o_drop), 64'(0));
      end
    join
    wait_idle();

    // Reset mid-frame with a pending frame queued.
    pulse(18'h0F0F0, 26'h0F0F0F0);
    pulse(18'h0E0E0, 26'h0E0E0E0);
    repeat (197) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst txd",  64'(bus.o_txd),  64'(1));
    chk("midrst busy", 64'(bus.o_busy), 64'(0));
    chk("midrst drop", 64'(bus.o_drop), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst pending lost", 64'(bus.o_busy), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.i_result = 18'h2D00D;
    bus.i_time   = 26'h1BADCAF;
    bus.i_valid  = 1'b1;
    @(negedge clk);
    bus.i_valid  = 1'b0;
    chk("postrst first txd",  64'(bus.o_txd),  64'(0));
    chk("postrst first busy", 64'(bus.o_busy), 64'(1));
    recv_frame("postrst");
    check_rx("postrst", "2D00D 1BADCAF");
    wait_idle();

    // Inputs wander during transmission; the frame keeps the captured values.
    r = 18'($urandom);
    t = 26'($urandom);
    pulse(r, t);
    fork
      recv_frame("hold");
      begin
        for (int k = 0; k < FRAME; k++) begin
          @(negedge clk);
          bus.i_result = 18'($urandom);
          bus.i_time   = 26'($urandom);
        end
      end
    join
    check_rx("hold", frame_text(r, t));
    wait_idle();

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 700)) @(negedge clk);
      pulse(18'($urandom), 26'($urandom));
    end
    wait_idle();
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached with %0d miscompares", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
